wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone (pipelined, with stall) arbiter for the peripheral bus.
- Master 0 is the MEM-stage data port. Master 1 is a secondary requester such as a debug/DMA port.
- The slave side drives the peripheral decode/UART chain.
- Round-robin grant; ownership is held for the whole CYC burst. Optional watchdog aborts hung slave cycles with an error.

Parameters:
- DATA_WIDTH, 32, width of the data and address buses.
- TIMEOUT_CYCLES, 255, ack-less cycles before abort; only used when WB_ARB_TIMEOUT_EN is defined.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 request signals
- m0_addr_i, m0_data_i  in  DATA_WIDTH  master 0 address / write data
- m0_stall_o, m0_ack_o, m0_err_o  out  1 each  master 0 responses
- m0_data_o  out  DATA_WIDTH  master 0 read data
- m1_*  (same set as m0_*)  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_addr_o, s_data_o  out  DATA_WIDTH  to slave
- s_stall_i, s_ack_i  in  1 each  from slave
- s_data_i  in  DATA_WIDTH  from slave
- grant_o  out  2  one-hot current owner; 00 = none

Behaviour:
- FSM states: IDLE, OWN0, OWN1, ABORT. Reset state is IDLE.
- State register, last_grant and timeout counter are asynchronously reset by rst_i.
- Reset values:
  - state = IDLE, last_grant = 1, so m0 wins the first tie.
  - grant_o = 00, counter = 0.
  - All m*_ack_o/err_o = 0; all m*_stall_o = 1.
  - s_cyc_o = s_stb_o = s_we_o = 0; s_addr_o = s_data_o = 0.
- IDLE:
  - Only m0_cyc_i: go to OWN0 next edge.
  - Only m1_cyc_i: go to OWN1 next edge.
  - Both: grant the master that is not last_grant.
  - Neither: stay.
  - Arbitration latency is 1 cycle; s_cyc_o is never asserted in IDLE.
- OWNx:
  - grant_o is one-hot for x; last_grant <= x on entry.
  - Slave outputs are a combinational copy of master x's cyc/stb/we/addr/data.
  - mx_stall_o = s_stall_i, mx_ack_o = s_ack_i, mx_data_o = s_data_i.
  - Non-owner sees stall = 1, ack = 0, err = 0, data = 0.
- Release:
  - When mx_cyc_i drops while in OWNx, the next state is decided in that same cycle.
  - If the other master's cyc is high, go directly to OWN(other). This gives back-to-back handover with no IDLE bubble.
  - Otherwise go to IDLE.
  - An ack arriving in the release cycle is still routed to the old owner.
- Non-owner requests never preempt an active owner, regardless of length.
- Read data and ack pass through combinationally; the arbiter adds zero latency inside a granted cycle.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous); the in-flight transaction is dropped.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle in OWNx with s_cyc_o = 1 and s_ack_i = 0; it clears on s_ack_i or on leaving OWNx.
  - When the counter equals TIMEOUT_CYCLES:
    - mx_err_o pulses high for exactly one cycle; mx_ack_o stays 0.
    - The next state is ABORT.
  - ABORT:
    - s_cyc_o = s_stb_o = 0; owner sees stall = 1.
    - grant_o is held until the owner drops cyc, then follow the same next-state rule as a normal release.
  - An ack arriving in the same cycle the counter hits TIMEOUT_CYCLES wins: no err, no ABORT.
- Undefined:
  - No counter logic; m*_err_o tied to 0.
  - ABORT is unreachable; cycles may hang indefinitely.

Test Plan:
- Single read: m0 cyc/stb, addr 0x2000_0004; slave acks with data 0x0000_00A5 two cycles later -> grant_o = 01 one cycle after request; m0_ack_o = 1 with m0_data_o = 0x0000_00A5; m1_stall_o = 1 throughout.
- Simultaneous requests after reset -> m0 granted first. Both re-request after m0 releases -> m1 granted next (grant_o = 10). Next tie -> m0.
- Handover: m0 drops cyc while m1_cyc_i is high -> grant_o goes 01 to 10 on the next edge with no 00 cycle; s_addr_o switches to m1_addr_i.
- Stall passthrough: slave holds s_stall_i = 1 for 3 cycles during an m1 write of 0xDEAD_BEEF -> m1_stall_o = 1 for 3 cycles; s_data_o = 0xDEAD_BEEF; s_we_o = 1.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave never acks -> m0_err_o pulses once after 4 ack-less cycles; s_cyc_o = 0 in the following cycle; grant holds until m0 drops cyc, then IDLE. Also: ack on the 4th cycle -> no err.
- Assert rst_i mid-transfer of an m1 write -> same cycle: s_cyc_o = 0, grant_o = 00, all stall_o = 1. After release, an m0/m1 tie grants m0.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave pipelined Wishbone arbiter: round-robin grant held for the whole CYC burst.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts ack-less slave cycles with an error.
//
// state | meaning
// IDLE  | no owner, slave bus quiet, waiting for a cyc request
// OWN0  | master 0 owns the slave bus, signals pass straight through
// OWN1  | master 1 owns the slave bus, signals pass straight through
// ABORT | owner timed out; slave cycle dropped, grant held until owner drops cyc
module wb_bus_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [DATA_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_data_i,
   output logic                  m0_stall_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic [DATA_WIDTH-1:0] m0_data_o,

   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [DATA_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_data_i,
   output logic                  m1_stall_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic [DATA_WIDTH-1:0] m1_data_o,

   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [DATA_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_data_o,
   input  logic                  s_stall_i,
   input  logic                  s_ack_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,

   output logic [1:0]            grant_o
);

   if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
      $error("wb_bus_arbiter: CNT_W too narrow to hold TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   last_grant_q;
   logic   owner_cyc;
   logic   other_cyc;
   logic   timeout_hit;

   // In OWNx and ABORT last_grant_q always names the current owner.
   assign owner_cyc = last_grant_q ? m1_cyc_i : m0_cyc_i;
   assign other_cyc = last_grant_q ? m0_cyc_i : m1_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic             own_active;

   assign own_active  = (state_q == OWN0) || (state_q == OWN1);
   // A same-cycle ack beats the watchdog.
   assign timeout_hit = own_active && owner_cyc && !s_ack_i && (cnt_q == TIMEOUT_VAL);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (!own_active || (state_d != state_q) || s_ack_i) begin
         cnt_q <= '0;
      end else if (owner_cyc) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_d == OWN0) begin
            last_grant_q <= 1'b0;
         end else if (state_d == OWN1) begin
            last_grant_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_grant_q ? OWN0 : OWN1;
            end else if (m0_cyc_i) begin
               state_d = OWN0;
            end else if (m1_cyc_i) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (!m0_cyc_i) begin
               state_d = m1_cyc_i ? OWN1 : IDLE;
            end else if (timeout_hit) begin
               state_d = ABORT;
            end
         end
         OWN1: begin
            if (!m1_cyc_i) begin
               state_d = m0_cyc_i ? OWN0 : IDLE;
            end else if (timeout_hit) begin
               state_d = ABORT;
            end
         end
         ABORT: begin
            if (!owner_cyc) begin
               if (other_cyc) begin
                  state_d = last_grant_q ? OWN0 : OWN1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_o    = 2'b00;
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_addr_o   = '0;
      s_data_o   = '0;
      m0_stall_o = 1'b1;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_data_o  = '0;
      m1_stall_o = 1'b1;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_data_o  = '0;
      case (state_q)
         OWN0: begin
            grant_o    = 2'b01;
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_stb_i;
            s_we_o     = m0_we_i;
            s_addr_o   = m0_addr_i;
            s_data_o   = m0_data_i;
            m0_stall_o = s_stall_i;
            m0_ack_o   = s_ack_i;
            m0_err_o   = timeout_hit;
            m0_data_o  = s_data_i;
         end
         OWN1: begin
            grant_o    = 2'b10;
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i;
            s_we_o     = m1_we_i;
            s_addr_o   = m1_addr_i;
            s_data_o   = m1_data_i;
            m1_stall_o = s_stall_i;
            m1_ack_o   = s_ack_i;
            m1_err_o   = timeout_hit;
            m1_data_o  = s_data_i;
         end
         ABORT: begin
            grant_o = last_grant_q ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed test-plan scenarios plus randomized traffic,
// all outputs compared every cycle against an ownership-level reference model.
module tb_wb_bus_arbiter;

   localparam int DW = 32;
   localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_cyc_i, m0_stb_i, m0_we_i;
   logic [DW-1:0] m0_addr_i, m0_data_i;
   logic          m0_stall_o, m0_ack_o, m0_err_o;
   logic [DW-1:0] m0_data_o;
   logic          m1_cyc_i, m1_stb_i, m1_we_i;
   logic [DW-1:0] m1_addr_i, m1_data_i;
   logic          m1_stall_o, m1_ack_o, m1_err_o;
   logic [DW-1:0] m1_data_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [DW-1:0] s_addr_o, s_data_o;
   logic          s_stall_i, s_ack_i;
   logic [DW-1:0] s_data_i;
   logic [1:0]    grant_o;

   wb_bus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
      .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_data_o(m0_data_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
      .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_data_o(m1_data_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_addr_o(s_addr_o), .s_data_o(s_data_o),
      .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
      .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, who won last, whether the burst was aborted,
   // and how many ack-less cycles the owner has waited.
   int owner    = -1;
   int last     = 1;
   bit aborting = 1'b0;
   int wait_cnt = 0;

   always @(posedge clk_i or posedge rst_i) begin
      bit mc[2];
      mc[0] = m0_cyc_i;
      mc[1] = m1_cyc_i;
      if (rst_i) begin
         owner = -1; last = 1; aborting = 1'b0; wait_cnt = 0;
      end else if (owner < 0) begin
         if (mc[0] && mc[1]) owner = 1 - last;
         else if (mc[0])     owner = 0;
         else if (mc[1])     owner = 1;
         if (owner >= 0) last = owner;
         wait_cnt = 0;
      end else if (!mc[owner]) begin
         aborting = 1'b0;
         wait_cnt = 0;
         if (mc[1 - owner]) begin
            owner = 1 - owner;
            last  = owner;
         end else begin
            owner = -1;
         end
      end else if (!aborting && TO_EN) begin
         if (s_ack_i)             wait_cnt = 0;
         else if (wait_cnt == TO) begin aborting = 1'b1; wait_cnt = 0; end
         else                     wait_cnt++;
      end
   end

   logic [1:0]  e_grant;
   logic [66:0] e_s;
   logic [34:0] e_m0, e_m1, e_resp;
   bit          e_err;
   bit          cmp_en = 1'b0;

   always @(negedge clk_i) begin
      if (cmp_en) begin
         e_grant = 2'b00;
         e_s     = '0;
         e_m0    = {1'b1, 1'b0, 1'b0, 32'h0};
         e_m1    = {1'b1, 1'b0, 1'b0, 32'h0};
         if (!rst_i && owner >= 0) begin
            e_grant = (owner == 0) ? 2'b01 : 2'b10;
            if (!aborting) begin
               e_err  = TO_EN && ((owner == 0) ? m0_cyc_i : m1_cyc_i) && !s_ack_i && (wait_cnt == TO);
               e_resp = {s_stall_i, s_ack_i, e_err, s_data_i};
               if (owner == 0) begin
                  e_s  = {m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i};
                  e_m0 = e_resp;
               end else begin
                  e_s  = {m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i};
                  e_m1 = e_resp;
               end
            end
         end
         chk("grant", 128'(grant_o), 128'(e_grant));
         chk("slave_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o}), 128'(e_s));
         chk("m0_resp", 128'({m0_stall_o, m0_ack_o, m0_err_o, m0_data_o}), 128'(e_m0));
         chk("m1_resp", 128'({m1_stall_o, m1_ack_o, m1_err_o, m1_data_o}), 128'(e_m1));
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0;
      s_stall_i = 0; s_ack_i = 0; s_data_i = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic rand_inputs();
      if ($urandom_range(3) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(3) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i  = ($urandom_range(1) != 0);
      m0_we_i   = ($urandom_range(1) != 0);
      m0_addr_i = $urandom();
      m0_data_i = $urandom();
      m1_stb_i  = ($urandom_range(1) != 0);
      m1_we_i   = ($urandom_range(1) != 0);
      m1_addr_i = $urandom();
      m1_data_i = $urandom();
      s_stall_i = ($urandom_range(3) == 0);
      s_ack_i   = ($urandom_range(2) == 0);
      s_data_i  = $urandom();
   endtask

   initial begin
      clear_inputs();
      rst_i  = 1'b1;
      cmp_en = 1'b1;
      step();
      @(negedge clk_i);
      chk("rst_grant", 128'(grant_o), 128'(2'b00));
      chk("rst_stall", 128'({m0_stall_o, m1_stall_o}), 128'(2'b11));
      chk("rst_s_cyc", 128'(s_cyc_o), 128'(1'b0));
      step();
      rst_i = 1'b0;

      // single read by m0
      step();
      m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h2000_0004;
      @(negedge clk_i);
      chk("rd_latency", 128'(grant_o), 128'(2'b00));
      step();
      @(negedge clk_i);
      chk("rd_grant", 128'(grant_o), 128'(2'b01));
      chk("rd_addr", 128'(s_addr_o), 128'(32'h2000_0004));
      step();
      m0_stb_i = 0;
      step();
      s_ack_i = 1; s_data_i = 32'h0000_00A5;
      @(negedge clk_i);
      chk("rd_ack", 128'({m0_ack_o, m0_data_o}), 128'({1'b1, 32'h0000_00A5}));
      chk("rd_m1_stall", 128'(m1_stall_o), 128'(1'b1));
      step();
      s_ack_i = 0; s_data_i = '0; m0_cyc_i = 0;
      step();
      @(negedge clk_i);
      chk("rd_release", 128'(grant_o), 128'(2'b00));

      // round-robin ties
      do_reset();
      m0_cyc_i = 1; m1_cyc_i = 1;
      step();
      @(negedge clk_i);
      chk("tie1", 128'(grant_o), 128'(2'b01));
      step();
      m0_cyc_i = 0; m1_cyc_i = 0;
      step();
      m0_cyc_i = 1; m1_cyc_i = 1;
      step();
      @(negedge clk_i);
      chk("tie2", 128'(grant_o), 128'(2'b10));
      step();
      m0_cyc_i = 0; m1_cyc_i = 0;
      step();
      m0_cyc_i = 1; m1_cyc_i = 1;
      step();
      @(negedge clk_i);
      chk("tie3", 128'(grant_o), 128'(2'b01));

      // handover m0 -> m1 without an idle bubble
      step();
      m0_cyc_i = 0; m1_stb_i = 1; m1_addr_i = 32'h3000_0010;
      @(negedge clk_i);
      chk("ho_release", 128'(grant_o), 128'(2'b01));
      step();
      @(negedge clk_i);
      chk("ho_grant", 128'(grant_o), 128'(2'b10));
      chk("ho_addr", 128'(s_addr_o), 128'(32'h3000_0010));

      // stall passthrough on an m1 write
      step();
      m1_we_i = 1; m1_data_i = 32'hDEAD_BEEF; s_stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("st_stall", 128'(m1_stall_o), 128'(1'b1));
         chk("st_wdata", 128'({s_we_o, s_data_o}), 128'({1'b1, 32'hDEAD_BEEF}));
         step();
      end
      s_stall_i = 0;
      @(negedge clk_i);
      chk("st_unstall", 128'(m1_stall_o), 128'(1'b0));

      // asynchronous reset in the middle of the m1 write
      step();
      #2;
      rst_i = 1'b1;
      #1;
      chk("mr_s_cyc", 128'(s_cyc_o), 128'(1'b0));
      chk("mr_grant", 128'(grant_o), 128'(2'b00));
      chk("mr_stall", 128'({m0_stall_o, m1_stall_o}), 128'(2'b11));
      step();
      rst_i = 1'b0; m0_cyc_i = 1;
      step();
      @(negedge clk_i);
      chk("mr_tie", 128'(grant_o), 128'(2'b01));
      step();
      clear_inputs();
      step();
      step();

`ifdef WB_ARB_TIMEOUT_EN
      // slave never acks: err after TO ack-less cycles, then abort
      m0_cyc_i = 1; m0_stb_i = 1;
      step();
      repeat (3) step();
      step();
      @(negedge clk_i);
      chk("to_err", 128'({m0_err_o, m0_ack_o}), 128'(2'b10));
      step();
      @(negedge clk_i);
      chk("to_abort", 128'({s_cyc_o, grant_o, m0_err_o, m0_stall_o}), 128'({1'b0, 2'b01, 1'b0, 1'b1}));
      step();
      m0_cyc_i = 0;
      @(negedge clk_i);
      chk("to_hold", 128'(grant_o), 128'(2'b01));
      step();
      @(negedge clk_i);
      chk("to_idle", 128'(grant_o), 128'(2'b00));
      // ack in the terminal cycle beats the watchdog
      m0_cyc_i = 1;
      step();
      repeat (3) step();
      step();
      s_ack_i = 1;
      @(negedge clk_i);
      chk("to_ack_wins", 128'({m0_err_o, m0_ack_o}), 128'(2'b01));
      step();
      @(negedge clk_i);
      chk("to_no_abort", 128'(grant_o), 128'(2'b01));
      clear_inputs();
      step();
      step();
`endif

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         step();
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
